// File: rtl/cpu_bus_master.sv
// cpu_bus_master: initiator of the cartridge CPU bus.
// Accepts single/burst read/write commands, generates M2-phased NES CPU
// bus cycles (addr, rw, data, m2) and returns read beats on a valid/ready
// response channel.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_rw/cmd_addr/cmd_wdata/cmd_len command payload (len = beats - 1)
//   rsp_valid/rsp_ready               read response handshake
//   rsp_data/rsp_drv                  read byte, mapper-drove-bus flag
//   done, busy                        completion pulse, command in progress
//   bus_addr/bus_rw/bus_m2            CPU bus address, r/w, M2 phase clock
//   bus_dout/bus_dout_oe              write data and its drive enable
//   map_cpu_oe/map_cpu_do             mapper read enable and read data
//
// Optional feature macro: CPU_BUS_OPEN_BUS_EN
//   defined   -> undriven reads return the last byte seen on the data bus
//   undefined -> undriven reads return 8'hFF
//
// Read beats spend one clock in WAIT_RSP (M2 low) to hand the byte over.
module cpu_bus_master #(
  parameter int unsigned M2_LO_CYC = 3,
  parameter int unsigned M2_HI_CYC = 3,
  parameter logic [15:0] IDLE_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_drv,
  output logic        done,
  output logic        busy,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic        bus_m2,
  output logic [7:0]  bus_dout,
  output logic        bus_dout_oe,
  input  logic        map_cpu_oe,
  input  logic [7:0]  map_cpu_do
);

  localparam int unsigned PH_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_WAIT} state_e;

  state_e state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_drv_q, rsp_drv_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic        bus_rw_q, bus_rw_d;
  logic        bus_m2_q, bus_m2_d;
  logic [7:0]  bus_dout_q, bus_dout_d;
  logic        bus_dout_oe_q, bus_dout_oe_d;

  logic cmd_fire, lo_last, hi_last, rsp_fire, beat_end, last_beat;
  logic [7:0] undriven_byte, rd_byte;

`ifdef CPU_BUS_OPEN_BUS_EN
  // Last byte seen on the data bus; when not valid, the address high byte.
  logic [7:0] ob_q, ob_d;
  logic       ob_vld_q, ob_vld_d;
  assign undriven_byte = ob_vld_q ? ob_q : addr_q[15:8];
`else
  assign undriven_byte = 8'hFF;
`endif

  assign rd_byte   = map_cpu_oe ? map_cpu_do : undriven_byte;
  assign cmd_fire  = cmd_valid & cmd_ready_q;
  assign lo_last   = (state_q == S_LO) && (ph_q == PH_W'(M2_LO_CYC - 1));
  assign hi_last   = (state_q == S_HI) && (ph_q == PH_W'(M2_HI_CYC - 1));
  assign rsp_fire  = rsp_valid_q & rsp_ready;
  assign beat_end  = (hi_last & ~rw_q) | ((state_q == S_WAIT) & rsp_fire);
  assign last_beat = (cnt_q == 8'd0);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ph_q          <= '0;
      rw_q          <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_drv_q     <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      bus_addr_q    <= IDLE_ADDR;
      bus_rw_q      <= 1'b1;
      bus_m2_q      <= 1'b0;
      bus_dout_q    <= '0;
      bus_dout_oe_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_drv_q     <= rsp_drv_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      bus_addr_q    <= bus_addr_d;
      bus_rw_q      <= bus_rw_d;
      bus_m2_q      <= bus_m2_d;
      bus_dout_q    <= bus_dout_d;
      bus_dout_oe_q <= bus_dout_oe_d;
    end
  end

`ifdef CPU_BUS_OPEN_BUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_q     <= '0;
      ob_vld_q <= 1'b0;
    end else begin
      ob_q     <= ob_d;
      ob_vld_q <= ob_vld_d;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_fire) state_d = S_LO;
      S_LO:   if (lo_last)  state_d = S_HI;
      S_HI:   if (hi_last && rw_q) state_d = S_WAIT;
      default: ;
    endcase
    if (beat_end) state_d = last_beat ? S_IDLE : S_LO;
  end

  // Output and datapath next values
  always_comb begin
    ph_d          = '0;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_drv_d     = rsp_drv_q;
    done_d        = 1'b0;
    busy_d        = busy_q;
    bus_addr_d    = bus_addr_q;
    bus_rw_d      = bus_rw_q;
    bus_m2_d      = bus_m2_q;
    bus_dout_d    = bus_dout_q;
    bus_dout_oe_d = bus_dout_oe_q;
`ifdef CPU_BUS_OPEN_BUS_EN
    ob_d          = ob_q;
    ob_vld_d      = ob_vld_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          rw_d        = cmd_rw;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          cnt_d       = cmd_len;
          busy_d      = 1'b1;
          cmd_ready_d = 1'b0;
          bus_addr_d  = cmd_addr;
          bus_rw_d    = cmd_rw;
        end
      end
      S_LO: begin
        ph_d = lo_last ? '0 : ph_q + PH_W'(1);
        if (lo_last) begin
          bus_m2_d = 1'b1;
          if (!rw_q) begin
            bus_dout_d    = wdata_q;
            bus_dout_oe_d = 1'b1;
          end
        end
      end
      S_HI: begin
        ph_d = hi_last ? '0 : ph_q + PH_W'(1);
        if (hi_last) begin
          bus_m2_d      = 1'b0;
          bus_dout_oe_d = 1'b0;
          if (rw_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_byte;
            rsp_drv_d   = map_cpu_oe;
`ifdef CPU_BUS_OPEN_BUS_EN
            ob_d     = map_cpu_do;
            ob_vld_d = map_cpu_oe;
          end else begin
            ob_d     = wdata_q;
            ob_vld_d = 1'b1;
`endif
          end
        end
      end
      S_WAIT: begin
        if (rsp_fire) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase

    // Beat completion: finish the command or advance to the next address
    if (beat_end) begin
      if (last_beat) begin
        bus_addr_d  = IDLE_ADDR;
        bus_rw_d    = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        cmd_ready_d = 1'b1;
      end else begin
        cnt_d      = cnt_q - 8'd1;
        addr_d     = addr_q + 16'd1;
        bus_addr_d = addr_q + 16'd1;
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_drv     = rsp_drv_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign bus_addr    = bus_addr_q;
  assign bus_rw      = bus_rw_q;
  assign bus_m2      = bus_m2_q;
  assign bus_dout    = bus_dout_q;
  assign bus_dout_oe = bus_dout_oe_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed testbench for cpu_bus_master (default parameters: 3 LO, 3 HI).
// Cycle i = i-th falling edge after the command handshake edge.
module tb_cpu_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw = 1'b1;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [7:0]  cmd_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_data;
  logic        rsp_drv;
  logic        done;
  logic        busy;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic        bus_m2;
  logic [7:0]  bus_dout;
  logic        bus_dout_oe;
  logic        map_cpu_oe = 1'b0;
  logic [7:0]  map_cpu_do;

  logic        map_by_addr = 1'b0;
  logic [7:0]  map_do_fixed = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  // Mapper model: fixed byte or address-derived byte
  assign map_cpu_do = map_by_addr ? (bus_addr[7:0] ^ 8'hA5) : map_do_fixed;

  always #5 clk = ~clk;

  cpu_bus_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_drv(rsp_drv), .done(done), .busy(busy),
    .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_m2(bus_m2),
    .bus_dout(bus_dout), .bus_dout_oe(bus_dout_oe),
    .map_cpu_oe(map_cpu_oe), .map_cpu_do(map_cpu_do)
  );

  task automatic send_cmd(input logic rw, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [7:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd; cmd_len = len;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [47:0] got, exp;
    pulse_reset();
    got = {bus_m2, bus_addr, bus_rw, bus_dout, bus_dout_oe, cmd_ready,
           rsp_valid, rsp_data, rsp_drv, done, busy, 6'd0};
    exp = {1'b0, 16'hFFFF, 1'b1, 8'h00, 1'b0, 1'b1,
           1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_state: got %h exp %h", got, exp);
    end
  endtask

  task automatic test_single_read();
    int rsp_cnt = 0;
    map_cpu_oe = 1'b1; map_do_fixed = 8'h5A; map_by_addr = 1'b0; rsp_ready = 1'b1;
    send_cmd(1'b1, 16'h8123, 8'h00, 8'd0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_m2 !== (i >= 4 && i <= 6)) begin
        n_err++; $display("FAIL rd1_m2 cyc %0d: got %b", i, bus_m2);
      end
      if (rsp_valid) rsp_cnt++;
      if (i == 1) begin
        n_cmp++;
        if ({bus_addr, bus_rw, busy, cmd_ready} !== {16'h8123, 1'b1, 1'b1, 1'b0}) begin
          n_err++; $display("FAIL rd1_addr: got %h/%b/%b/%b exp 8123/1/1/0",
                            bus_addr, bus_rw, busy, cmd_ready);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_drv} !== {1'b1, 8'h5A, 1'b1}) begin
          n_err++; $display("FAIL rd1_rsp: got %b/%h/%b exp 1/5a/1",
                            rsp_valid, rsp_data, rsp_drv);
        end
      end
      n_cmp++;
      if (done !== (i == 8)) begin
        n_err++; $display("FAIL rd1_done cyc %0d: got %b", i, done);
      end
      if (i == 8) begin
        n_cmp++;
        if ({bus_addr, busy, cmd_ready} !== {16'hFFFF, 1'b0, 1'b1}) begin
          n_err++; $display("FAIL rd1_idle: got %h/%b/%b exp ffff/0/1",
                            bus_addr, busy, cmd_ready);
        end
      end
      n_cmp++;
      if (bus_dout_oe !== 1'b0) begin
        n_err++; $display("FAIL rd1_oe cyc %0d: got %b exp 0", i, bus_dout_oe);
      end
    end
    n_cmp++;
    if (rsp_cnt != 1) begin
      n_err++; $display("FAIL rd1_rsp_cnt: got %0d exp 1", rsp_cnt);
    end
  endtask

  task automatic test_write_burst();
    int done_cnt = 0, rsp_cnt = 0, b, p;
    map_cpu_oe = 1'b0;
    send_cmd(1'b0, 16'h6000, 8'h3C, 8'd3);
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk);
      b = (i - 1) / 6; p = (i - 1) % 6;
      if (done) done_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (i <= 24) begin
        n_cmp++;
        if ({bus_addr, bus_rw, bus_m2, bus_dout_oe} !==
            {16'h6000 + 16'(b), 1'b0, (p >= 3), (p >= 3)}) begin
          n_err++; $display("FAIL wr_cycle cyc %0d: got %h/%b/%b/%b", i,
                            bus_addr, bus_rw, bus_m2, bus_dout_oe);
        end
        if (p >= 3) begin
          n_cmp++;
          if (bus_dout !== 8'h3C) begin
            n_err++; $display("FAIL wr_dout cyc %0d: got %h exp 3c", i, bus_dout);
          end
        end
      end else begin
        n_cmp++;
        if (bus_dout_oe !== 1'b0 || bus_m2 !== 1'b0) begin
          n_err++; $display("FAIL wr_post cyc %0d: got oe %b m2 %b", i, bus_dout_oe, bus_m2);
        end
      end
      if (i == 25) begin
        n_cmp++;
        if ({done, bus_addr, bus_rw} !== {1'b1, 16'hFFFF, 1'b1}) begin
          n_err++; $display("FAIL wr_done: got %b/%h/%b exp 1/ffff/1", done, bus_addr, bus_rw);
        end
      end
    end
    n_cmp++;
    if (done_cnt != 1 || rsp_cnt != 0) begin
      n_err++; $display("FAIL wr_counts: got done %0d rsp %0d exp 1 0", done_cnt, rsp_cnt);
    end
  endtask

  task automatic test_read_wrap();
    logic [15:0] exp_addr [3];
    int b, p, k = 0;
    exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000;
    map_cpu_oe = 1'b1; map_by_addr = 1'b1; rsp_ready = 1'b1;
    send_cmd(1'b1, 16'hFFFE, 8'h00, 8'd2);
    for (int i = 1; i <= 23; i++) begin
      @(negedge clk);
      b = (i - 1) / 7; p = (i - 1) % 7;
      if (i <= 21) begin
        n_cmp++;
        if ({bus_addr, bus_m2, rsp_valid} !== {exp_addr[b], (p >= 3 && p <= 5), (p == 6)}) begin
          n_err++; $display("FAIL wrap_cycle cyc %0d: got %h/%b/%b", i, bus_addr, bus_m2, rsp_valid);
        end
        if (p == 6) begin
          n_cmp++;
          if (rsp_data !== (exp_addr[k][7:0] ^ 8'hA5)) begin
            n_err++; $display("FAIL wrap_data beat %0d: got %h exp %h", k, rsp_data,
                              exp_addr[k][7:0] ^ 8'hA5);
          end
          k++;
        end
      end
      n_cmp++;
      if (done !== (i == 22)) begin
        n_err++; $display("FAIL wrap_done cyc %0d: got %b", i, done);
      end
    end
    map_by_addr = 1'b0;
  endtask

  task automatic test_backpressure();
    map_cpu_oe = 1'b1; map_by_addr = 1'b1; rsp_ready = 1'b0;
    send_cmd(1'b1, 16'h1234, 8'h00, 8'd1);
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      if (i >= 7 && i <= 17) begin
        n_cmp++;
        if ({rsp_valid, rsp_data, bus_m2, bus_addr} !== {1'b1, 8'h91, 1'b0, 16'h1234}) begin
          n_err++; $display("FAIL bp_hold cyc %0d: got %b/%h/%b/%h exp 1/91/0/1234", i,
                            rsp_valid, rsp_data, bus_m2, bus_addr);
        end
      end
      if (i == 18) begin
        n_cmp++;
        if ({rsp_valid, bus_addr, bus_m2} !== {1'b0, 16'h1235, 1'b0}) begin
          n_err++; $display("FAIL bp_beat2: got %b/%h/%b exp 0/1235/0", rsp_valid, bus_addr, bus_m2);
        end
      end
      if (i >= 21 && i <= 23) begin
        n_cmp++;
        if (bus_m2 !== 1'b1) begin
          n_err++; $display("FAIL bp_hi cyc %0d: got %b exp 1", i, bus_m2);
        end
      end
      if (i == 24) begin
        n_cmp++;
        if ({rsp_valid, rsp_data} !== {1'b1, 8'h90}) begin
          n_err++; $display("FAIL bp_rsp2: got %b/%h exp 1/90", rsp_valid, rsp_data);
        end
      end
      n_cmp++;
      if (done !== (i == 25)) begin
        n_err++; $display("FAIL bp_done cyc %0d: got %b", i, done);
      end
      rsp_ready = (i >= 17);
    end
    map_by_addr = 1'b0; rsp_ready = 1'b1;
  endtask

  task automatic test_undriven();
    logic [7:0] exp_b;
`ifdef CPU_BUS_OPEN_BUS_EN
    exp_b = 8'h40;
`else
    exp_b = 8'hFF;
`endif
    pulse_reset();
    map_cpu_oe = 1'b0; map_do_fixed = 8'h12; rsp_ready = 1'b1;
    send_cmd(1'b1, 16'h4020, 8'h00, 8'd0);
    repeat (7) @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_data, rsp_drv} !== {1'b1, exp_b, 1'b0}) begin
      n_err++; $display("FAIL undriven: got %b/%h/%b exp 1/%h/0", rsp_valid, rsp_data, rsp_drv, exp_b);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int done_cnt = 0;
    map_cpu_oe = 1'b0;
    send_cmd(1'b0, 16'h7000, 8'hAA, 8'd3);
    repeat (11) @(negedge clk);
    n_cmp++;
    if ({bus_m2, bus_dout_oe, bus_addr} !== {1'b1, 1'b1, 16'h7001}) begin
      n_err++; $display("FAIL rst_pre: got %b/%b/%h exp 1/1/7001", bus_m2, bus_dout_oe, bus_addr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_m2, bus_dout_oe, busy, cmd_ready, bus_addr} !== {1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF}) begin
      n_err++; $display("FAIL rst_async: got %b/%b/%b/%b/%h exp 0/0/0/1/ffff",
                        bus_m2, bus_dout_oe, busy, cmd_ready, bus_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy || bus_m2) done_cnt++;
    end
    n_cmp++;
    if (done_cnt != 0) begin
      n_err++; $display("FAIL rst_no_done: got %0d active cycles exp 0", done_cnt);
    end
    send_cmd(1'b0, 16'h0100, 8'h77, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 4) begin
        n_cmp++;
        if ({bus_addr, bus_m2, bus_dout_oe, bus_dout} !== {16'h0100, 1'b1, 1'b1, 8'h77}) begin
          n_err++; $display("FAIL rst_next_wr: got %h/%b/%b/%h exp 0100/1/1/77",
                            bus_addr, bus_m2, bus_dout_oe, bus_dout);
        end
      end
      n_cmp++;
      if (done !== (i == 7)) begin
        n_err++; $display("FAIL rst_next_done cyc %0d: got %b", i, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_read_wrap();
    test_backpressure();
    test_undriven();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Initiator end of the cartridge CPU bus. Mapper modules respond on this bus; this block drives it.
- Takes single or burst read/write commands from an internal controller (test sequencer, save-state/dump engine).
- Generates M2-phased NES CPU bus cycles: addr, rw, data, m2.
- Samples the mapper's read output (map_cpu_oe / map_cpu_do) and returns read data over a valid/ready response channel.

Parameters:
- M2_LO_CYC, 3, clocks per bus cycle with M2 low (address/rw setup phase); legal range 1..15.
- M2_HI_CYC, 3, clocks per bus cycle with M2 high (data phase); legal range 1..15.
- IDLE_ADDR, 16'hFFFF, address driven while no cycle is in progress.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both valid and ready are high
- cmd_rw  in  1  1=read, 0=write
- cmd_addr  in  16  start address
- cmd_wdata  in  8  write data, same byte for every write beat
- cmd_len  in  8  beats minus one (0 = 1 beat, 255 = 256 beats)
- rsp_valid  out  1  read beat data available
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  8  read byte
- rsp_drv  out  1  mapper drove the bus (map_cpu_oe) on this beat
- done  out  1  one-clock pulse after the last beat of a command completes
- busy  out  1  a command is in progress
- bus_addr  out  16  CPU address bus
- bus_rw  out  1  CPU r/w, 1=read
- bus_m2  out  1  M2 phase clock
- bus_dout  out  8  write data to the bus
- bus_dout_oe  out  1  master drives the data bus
- map_cpu_oe  in  1  mapper read enable
- map_cpu_do  in  8  mapper read data

Behaviour:
- Clock and reset: single clock domain `clk`; `rst_n` is asynchronous, active-low.
- Reset values: bus_m2=0, bus_addr=IDLE_ADDR, bus_rw=1, bus_dout=0, bus_dout_oe=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_drv=0, done=0, busy=0. All registers are reset.
- FSM states: IDLE, LO, HI, WAIT_RSP.
- IDLE:
  - cmd_ready=1.
  - On handshake: latch rw, addr, wdata, and the beat counter (cmd_len); set busy=1 and cmd_ready=0; go to LO.
- LO:
  - bus_m2=0; bus_addr=current address; bus_rw=latched rw; bus_dout_oe=0.
  - Stay M2_LO_CYC clocks (phase counter), then go to HI.
- HI:
  - bus_m2=1. For writes: bus_dout=wdata and bus_dout_oe=1 for all M2_HI_CYC clocks.
  - Reads are sampled on the last HI clock: rsp_data=map_cpu_oe ? map_cpu_do : 8'hFF; rsp_drv=map_cpu_oe.
  - After the last HI clock:
    - Read beat: set rsp_valid and go to WAIT_RSP.
    - Write beat: go directly to beat completion.
- WAIT_RSP:
  - bus_m2=0; address and rw are held.
  - Exits on the clock where rsp_valid & rsp_ready; rsp_valid clears that edge.
  - Backpressure stretches the M2-low time only; M2 never pauses high.
- Beat completion:
  - If the beat counter is 0: return to IDLE, bus_addr=IDLE_ADDR, bus_rw=1, busy=0, done pulses 1 clock, cmd_ready=1 the same cycle.
  - Otherwise: decrement the counter, address += 1 (16-bit wrap, FFFF -> 0000), go to LO.
- Bus cycle period: M2_LO_CYC + M2_HI_CYC clocks when there is no backpressure. Back-to-back beats are contiguous.
- rsp_valid may be high when entering IDLE only if the consumer has not accepted it yet. This is impossible by construction, because WAIT_RSP must complete before completion.
- A new command is never accepted while busy.
- Reset mid-cycle: all outputs return to reset values immediately (bus_m2 drops asynchronously). Partial bursts are discarded and no done pulse is produced.
- bus_dout_oe is never high in LO, WAIT_RSP or IDLE, so there is no contention with the mapper during the address phase.

Optional Feature:
- Macro: CPU_BUS_OPEN_BUS_EN.
- Defined: reads where map_cpu_oe=0 return the open-bus value, i.e. the last byte seen on the data bus. That byte is:
  - the previous read sample; or
  - the write data of the previous write beat; or
  - bus_addr[15:8] after reset and after any beat where nothing drove the bus.
- Not defined: undriven reads return 8'hFF. The open-bus tracking register is not synthesized.
- rsp_drv behaves identically in both builds.

Test Plan:
- Single read, addr 8123, mapper oe=1, do=5A, rsp_ready tied 1 -> exactly one LO(3)+HI(3) cycle; rsp_valid with 5A, rsp_drv=1; done 1 clock later; bus_addr returns to FFFF.
- Write burst, addr 6000, wdata 3C, len 3 -> 4 write cycles at 6000..6003; bus_dout_oe high only in the 4 HI phases; no rsp_valid; one done pulse.
- Read burst, addr FFFE, len 2 -> addresses FFFE, FFFF, 0000 (wrap); 3 responses in order.
- Backpressure: read burst of 2, rsp_ready low for 10 clocks after the first response -> M2 held low 10 extra clocks; second beat starts only after acceptance; rsp_data stable while valid.
- Undriven read, addr 4020, oe=0 -> rsp_data=FF, rsp_drv=0. With CPU_BUS_OPEN_BUS_EN, a read immediately after reset returns 40.
- Assert rst_n low during HI of beat 2 of a 4-beat write -> bus_m2=0, bus_dout_oe=0, busy=0 asynchronously; no done pulse; the next command executes normally.
